gpio_wb_ctrl: RTL and testbench
===============================

GPIO_WB_CTRL -- requirements
Module: gpio_wb_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone base address; only bits [31:8] are decoded.
REQ-002 SHALL have parameter NGPIO, default 38, number of GPIO pins.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk_i input 1, the single clock; rst_i input 1, asynchronous active-high reset.
REQ-004 wbs_stb_i input 1, Wishbone strobe; wbs_cyc_i input 1, Wishbone cycle; wbs_we_i input 1, write enable.
REQ-005 wbs_sel_i input 4, byte lanes; wbs_dat_i input 32, write data; wbs_adr_i input 32, byte address.
REQ-006 wbs_ack_o output 1, acknowledge; wbs_dat_o output 32, read data.
REQ-007 gpio_i input NGPIO, pad inputs (asynchronous).
REQ-008 gpio_o output NGPIO, pad outputs.
REQ-009 gpio_oeb_no output NGPIO, active-low output enable.
REQ-010 irq_o output 1, level interrupt.

Function
REQ-011 Register map, by byte offset from the base:
- 0x00 OUT_LO, 0x04 OUT_HI: gpio_o.
- 0x08 OEB_LO, 0x0C OEB_HI: gpio_oeb_no.
- 0x10 IN_LO, 0x14 IN_HI: synchronized inputs, read-only.
- 0x18 IEN_LO, 0x1C IEN_HI: interrupt enables.
- 0x20 IST_LO, 0x24 IST_HI: status, write-1-to-clear.
- LO words cover bits [31:0]; HI words cover bits [NGPIO-1:32]; unused HI bits read 0.
REQ-012 Selection: the slave is selected when wbs_cyc_i & wbs_stb_i, wbs_adr_i[31:8]==BASE_ADDR[31:8], and wbs_ack_o==0.
REQ-013 Acknowledge: wbs_ack_o pulses high for exactly one cycle, in the cycle after selection.
- Write data is committed on the selection edge.
- wbs_dat_o is valid while wbs_ack_o is high and 0 otherwise.
REQ-014 A held strobe yields one ack every second cycle; back-to-back accesses are never acked in consecutive cycles.
REQ-015 Addresses outside the base page are never acked; unmapped offsets within the page ack, read 0, and ignore writes.
REQ-016 Writes honour wbs_sel_i per byte lane; unselected bytes are unchanged.
REQ-017 Input synchronization: gpio_i passes through a 2-flop synchronizer; IN reflects a pad change 2 cycles later.
REQ-018 Edge detection: a rising edge is sync_q & ~prev_q per bit.
- A detected edge sets the IST bit regardless of IEN.
- A pad rise reaches IST 3 cycles later and irq_o 4 cycles later.
REQ-019 irq_o is registered and equals |(IST & IEN) of the previous cycle.
REQ-020 If an edge and a W1C clear hit the same bit in the same cycle, set wins.
REQ-021 A 2-bit settle counter counts 0 to 3 after reset; edge detection is suppressed until it saturates, so high pads at reset raise no status.
REQ-022 Reads of IST return current status; reads have no side effects.
REQ-023 Deasserting cyc/stb in the ack cycle is legal; a strobe dropped before selection has no effect.

Reset
REQ-024 On rst_i assertion, all state clears asynchronously:
- gpio_o=0; gpio_oeb_no=all 1s (all inputs).
- IEN=0, IST=0, irq_o=0.
- wbs_ack_o=0, wbs_dat_o=0.
- Synchronizer and prev flops =0; settle counter =0.
REQ-025 Reset asserted mid-access aborts it; no ack is issued after reset release for that access.

Structure
REQ-026 Register offset constants and the LO/HI word width SHALL reside in shared package gpio_pkg.
REQ-027 The 2-flop synchronizer plus edge detector SHALL be one sub-module, gpio_sync_edge, parameterized by width.
REQ-028 Target size is 120-400 RTL lines; no memories and no combinational paths from gpio_i to any output.

Verification
REQ-029 Reset: assert rst_i mid-cycle -> gpio_oeb_no=38'h3F_FFFF_FFFF, gpio_o=0, irq_o=0 immediately, no ack after release.
REQ-030 Write OUT_LO=32'hA5A5_5A5A with sel=4'b0011 after reset -> gpio_o[31:0]=32'h0000_5A5A; ack exactly one cycle after selection.
REQ-031 Set IEN_HI=0x20, then pulse gpio_i[37] rising -> IST_HI bit5 set at +3 cycles, irq_o high at +4; W1C 0x20 -> irq_o low one cycle after commit.
REQ-032 Hold gpio_i[0]=1 through reset release -> IST_LO stays 0 after 10 cycles.
REQ-033 Held strobe to 0x10 for 6 cycles -> exactly 3 acks, alternating; address 0x3000_0100 -> no ack for 10 cycles.
REQ-034 Rising edge on bit 3 coincides with W1C of bit 3 -> IST_LO bit3 remains 1.

Source files
------------

// File: rtl/gpio_pkg.sv
// Register map offsets and word geometry shared by the Wishbone GPIO block.
package gpio_pkg;

    localparam int WORD_W = 32;

    localparam logic [7:0] OFS_OUT_LO = 8'h00;
    localparam logic [7:0] OFS_OUT_HI = 8'h04;
    localparam logic [7:0] OFS_OEB_LO = 8'h08;
    localparam logic [7:0] OFS_OEB_HI = 8'h0C;
    localparam logic [7:0] OFS_IN_LO  = 8'h10;
    localparam logic [7:0] OFS_IN_HI  = 8'h14;
    localparam logic [7:0] OFS_IEN_LO = 8'h18;
    localparam logic [7:0] OFS_IEN_HI = 8'h1C;
    localparam logic [7:0] OFS_IST_LO = 8'h20;
    localparam logic [7:0] OFS_IST_HI = 8'h24;

    // Expands Wishbone byte selects into a per-bit write mask.
    function automatic logic [WORD_W-1:0] lane_mask(input logic [3:0] sel);
        logic [WORD_W-1:0] m;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Two-flop pad synchronizer with rising-edge detect, gated until a reset settle count saturates.
// Latency: sync_o 2 cycles after a pad change; rise_o asserted combinationally in the following cycle.
// Backpressure: none, free-running every cycle.
module gpio_sync_edge #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] async_i,
    output logic [W-1:0] sync_o,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;
    logic [W-1:0] prev_q;
    logic [1:0]   settle_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q   <= '0;
            sync_q   <= '0;
            prev_q   <= '0;
            settle_q <= 2'd0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            if (settle_q != 2'd3) begin
                settle_q <= settle_q + 2'd1;
            end
        end
    end

    // Pads already high at reset look like a rise once; the settle count hides that.
    assign sync_o = sync_q;
    assign rise_o = (settle_q == 2'd3) ? (sync_q & ~prev_q) : '0;

endmodule

// File: rtl/gpio_wb_ctrl.sv
// Wishbone slave GPIO: output/enable registers, synchronized inputs, rising-edge status with W1C and level irq.
// Latency: ack one cycle after selection; pad rise reaches status in 3 cycles, irq_o in 4.
// Backpressure: none; a held strobe is acked every second cycle since the ack blocks reselection.
module gpio_wb_ctrl
    import gpio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          NGPIO     = 38
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_dat_i,
    input  logic [31:0]      wbs_adr_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    input  logic [NGPIO-1:0] gpio_i,
    output logic [NGPIO-1:0] gpio_o,
    output logic [NGPIO-1:0] gpio_oeb_no,
    output logic             irq_o
);

    logic [NGPIO-1:0]  out_q, oeb_q, ien_q, ist_q;
    logic [NGPIO-1:0]  in_sync, rise;
    logic [NGPIO-1:0]  wdata, wmask_lo, wmask_hi;
    logic [NGPIO-1:0]  m_out, m_oeb, m_ien, m_ist;
    logic [WORD_W-1:0] lmask, rd_dat;
    logic [7:0]        ofs;
    logic              hit, wr;

    gpio_sync_edge #(.W(NGPIO)) u_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (gpio_i),
        .sync_o  (in_sync),
        .rise_o  (rise)
    );

    assign ofs   = wbs_adr_i[7:0];
    assign hit   = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:8] == BASE_ADDR[31:8]) && !wbs_ack_o;
    assign wr    = hit && wbs_we_i;
    assign lmask = lane_mask(wbs_sel_i);

    // Map the 32-bit bus word onto pad bits: LO covers [31:0], HI covers [NGPIO-1:32].
    always_comb begin
        for (int i = 0; i < NGPIO; i++) begin
            wdata[i]    = wbs_dat_i[i % WORD_W];
            wmask_lo[i] = (i < WORD_W) && lmask[i % WORD_W];
            wmask_hi[i] = (i >= WORD_W) && lmask[i % WORD_W];
        end
    end

    function automatic logic [NGPIO-1:0] word_mask(input logic en, input logic [7:0] at,
                                                   input logic [7:0] lo_ofs, input logic [7:0] hi_ofs,
                                                   input logic [NGPIO-1:0] lo_m, input logic [NGPIO-1:0] hi_m);
        if (!en)          return '0;
        if (at == lo_ofs) return lo_m;
        if (at == hi_ofs) return hi_m;
        return '0;
    endfunction

    function automatic logic [WORD_W-1:0] hi_word(input logic [NGPIO-1:0] v);
        return WORD_W'(v[NGPIO-1:WORD_W]);
    endfunction

    assign m_out = word_mask(wr, ofs, OFS_OUT_LO, OFS_OUT_HI, wmask_lo, wmask_hi);
    assign m_oeb = word_mask(wr, ofs, OFS_OEB_LO, OFS_OEB_HI, wmask_lo, wmask_hi);
    assign m_ien = word_mask(wr, ofs, OFS_IEN_LO, OFS_IEN_HI, wmask_lo, wmask_hi);
    assign m_ist = word_mask(wr, ofs, OFS_IST_LO, OFS_IST_HI, wmask_lo, wmask_hi);

    always_comb begin
        rd_dat = '0;
        case (ofs)
            OFS_OUT_LO: rd_dat = out_q[WORD_W-1:0];
            OFS_OUT_HI: rd_dat = hi_word(out_q);
            OFS_OEB_LO: rd_dat = oeb_q[WORD_W-1:0];
            OFS_OEB_HI: rd_dat = hi_word(oeb_q);
            OFS_IN_LO:  rd_dat = in_sync[WORD_W-1:0];
            OFS_IN_HI:  rd_dat = hi_word(in_sync);
            OFS_IEN_LO: rd_dat = ien_q[WORD_W-1:0];
            OFS_IEN_HI: rd_dat = hi_word(ien_q);
            OFS_IST_LO: rd_dat = ist_q[WORD_W-1:0];
            OFS_IST_HI: rd_dat = hi_word(ist_q);
            default:    rd_dat = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_q     <= '0;
            oeb_q     <= '1;
            ien_q     <= '0;
            ist_q     <= '0;
            irq_o     <= 1'b0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= hit;
            wbs_dat_o <= (hit && !wbs_we_i) ? rd_dat : '0;
            out_q     <= (out_q & ~m_out) | (wdata & m_out);
            oeb_q     <= (oeb_q & ~m_oeb) | (wdata & m_oeb);
            ien_q     <= (ien_q & ~m_ien) | (wdata & m_ien);
            // A same-cycle edge re-sets a bit the W1C is clearing.
            ist_q     <= (ist_q & ~(m_ist & wdata)) | rise;
            irq_o     <= |(ist_q & ien_q);
        end
    end

    assign gpio_o      = out_q;
    assign gpio_oeb_no = oeb_q;

endmodule

// File: tb/tb_gpio_wb_ctrl.sv
// Scoreboard bench for gpio_wb_ctrl: random bus traffic against a word/byte-level register model,
// plus directed reset, edge-timing, held-strobe and set-vs-clear scenarios.
module tb_gpio_wb_ctrl;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int          N    = 38;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]    wbs_sel_i;
    logic [31:0]   wbs_dat_i, wbs_adr_i;
    logic          wbs_ack_o;
    logic [31:0]   wbs_dat_o;
    logic [N-1:0]  gpio_i, gpio_o, gpio_oeb_no;
    logic          irq_o;

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   exp_q[$];
    logic [N-1:0]  m_out, m_oeb, m_ien, m_ist;
    logic          prev_ack = 1'b0;

    always #5 clk = ~clk;

    gpio_wb_ctrl #(.BASE_ADDR(BASE), .NGPIO(N)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_we_i    (wbs_we_i),
        .wbs_sel_i   (wbs_sel_i),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_adr_i   (wbs_adr_i),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_dat_o   (wbs_dat_o),
        .gpio_i      (gpio_i),
        .gpio_o      (gpio_o),
        .gpio_oeb_no (gpio_oeb_no),
        .irq_o       (irq_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Byte-lane replacement on a 64-bit view of a register (LO word = bytes 0-3, HI word = bytes 4-7).
    function automatic logic [N-1:0] lanes(input logic [N-1:0] old, input logic hi,
                                           input logic [31:0] dat, input logic [3:0] sel);
        logic [63:0] w;
        w = 64'(old);
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) w[(hi ? 32 : 0) + 8*b +: 8] = dat[8*b +: 8];
        end
        return w[N-1:0];
    endfunction

    function automatic logic mapped(input logic [7:0] ofs);
        return (ofs <= 8'h24) && (ofs[1:0] == 2'b00);
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] ofs);
        logic [63:0] w;
        if (!mapped(ofs)) return 32'h0;
        case (ofs[7:3])
            5'd0:    w = 64'(m_out);
            5'd1:    w = 64'(m_oeb);
            5'd2:    w = 64'(gpio_i);
            5'd3:    w = 64'(m_ien);
            default: w = 64'(m_ist);
        endcase
        return ofs[2] ? w[63:32] : w[31:0];
    endfunction

    task automatic model_write(input logic [7:0] ofs, input logic [31:0] dat, input logic [3:0] sel);
        logic hi;
        hi = ofs[2];
        if (!mapped(ofs)) return;
        case (ofs[7:3])
            5'd0:    m_out = lanes(m_out, hi, dat, sel);
            5'd1:    m_oeb = lanes(m_oeb, hi, dat, sel);
            5'd3:    m_ien = lanes(m_ien, hi, dat, sel);
            5'd4:    m_ist = m_ist & ~lanes('0, hi, dat, sel);
            default: ;
        endcase
    endtask

    // Any pad going 0->1 latches its status bit.
    task automatic set_pads(input logic [N-1:0] np);
        m_ist  = m_ist | (np & ~gpio_i);
        gpio_i = np;
    endtask

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called and returns at #1 after a rising edge.
    task automatic wb_xfer(input logic we, input logic [7:0] ofs, input logic [31:0] dat,
                           input logic [3:0] sel, output logic irq_at_ack);
        int lat;
        exp_q.push_back(we ? 32'h0 : model_read(ofs));
        if (we) model_write(ofs, dat, sel);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = BASE | 32'(ofs);
        wbs_dat_i = dat;
        wbs_sel_i = sel;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (wbs_ack_o !== 1'b1 && lat < 20);
        check("ack_latency", 64'(lat), 64'd1);
        irq_at_ack = irq_o;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        cycle(1);
        check("ack_width", 64'(wbs_ack_o), 64'd0);
        check("irq_level", 64'(irq_o), 64'(|(m_ist & m_ien)));
        check("gpio_o", 64'(gpio_o), 64'(m_out));
        check("gpio_oeb_no", 64'(gpio_oeb_no), 64'(m_oeb));
    endtask

    // Monitor: every ack consumes one scoreboard entry; idle data must be zero.
    always @(negedge clk) begin
        logic [31:0] e;
        if (wbs_ack_o === 1'b1) begin
            check("ack_not_consecutive", 64'(prev_ack), 64'd0);
            check("ack_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rd_dat", 64'(wbs_dat_o), 64'(e));
            end
        end else begin
            check("dat_idle_zero", 64'(wbs_dat_o), 64'd0);
        end
        prev_ack = wbs_ack_o;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit, got %0t expected < 400000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic          irqv;
        logic [63:0]   r64;
        logic [N-1:0]  np;
        logic [5:0]    pat;
        logic          irq_t [1:4];
        int            acks;
        logic [7:0]    ofs;
        logic [7:0]    ofs_tab [14] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18,
                                        8'h1C, 8'h20, 8'h24, 8'h28, 8'h2C, 8'h40, 8'hFC};

        rst_i = 1'b1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_dat_i = 32'h0; wbs_adr_i = 32'h0;
        gpio_i = 38'h1;
        m_out = '0; m_oeb = '1; m_ien = '0; m_ist = '0;

        #2;
        check("rst_gpio_o", 64'(gpio_o), 64'd0);
        check("rst_oeb", 64'(gpio_oeb_no), 64'h3F_FFFF_FFFF);
        check("rst_irq", 64'(irq_o), 64'd0);
        check("rst_ack", 64'(wbs_ack_o), 64'd0);
        check("rst_dat", 64'(wbs_dat_o), 64'd0);

        // Pad 0 held high through reset release must not raise status.
        cycle(3);
        rst_i = 1'b0;
        cycle(10);
        wb_xfer(1'b0, 8'h20, 32'h0, 4'hF, irqv);
        wb_xfer(1'b0, 8'h10, 32'h0, 4'hF, irqv);

        wb_xfer(1'b1, 8'h00, 32'hA5A5_5A5A, 4'b0011, irqv);
        check("out_lo_bytesel", 64'(gpio_o[31:0]), 64'h0000_5A5A);

        // Held read strobe on IN_LO for six cycles: ack every other cycle.
        repeat (3) exp_q.push_back(model_read(8'h10));
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = BASE | 32'h10; wbs_sel_i = 4'hF;
        for (int k = 0; k < 6; k++) begin
            cycle(1);
            pat[k] = wbs_ack_o;
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        check("held_ack_pattern", 64'(pat), 64'(6'b010101));
        cycle(1);

        // Outside the base page: never acked.
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = 32'h3000_0100;
        acks = 0;
        for (int k = 0; k < 10; k++) begin
            cycle(1);
            acks += int'(wbs_ack_o);
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        check("off_page_acks", 64'(acks), 64'd0);
        cycle(1);

        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                r64 = {$urandom(), $urandom()};
                set_pads(r64[N-1:0]);
                cycle(4);
                check("irq_after_pads", 64'(irq_o), 64'(|(m_ist & m_ien)));
            end
            ofs = ofs_tab[$urandom_range(0, 13)];
            wb_xfer(1'($urandom_range(0, 1)), ofs, $urandom(), 4'($urandom()), irqv);
        end

        // Pad 37 rise with only IEN bit 37 enabled: irq exactly 4 cycles after the pad.
        np = gpio_i; np[37] = 1'b0;
        set_pads(np);
        cycle(4);
        wb_xfer(1'b1, 8'h18, 32'h0, 4'hF, irqv);
        wb_xfer(1'b1, 8'h1C, 32'h20, 4'hF, irqv);
        wb_xfer(1'b1, 8'h24, 32'hFFFF_FFFF, 4'hF, irqv);
        check("irq_before_rise", 64'(irq_o), 64'd0);
        np[37] = 1'b1;
        set_pads(np);
        for (int k = 1; k <= 4; k++) begin
            cycle(1);
            irq_t[k] = irq_o;
        end
        check("irq_at_plus3", 64'(irq_t[3]), 64'd0);
        check("irq_at_plus4", 64'(irq_t[4]), 64'd1);
        wb_xfer(1'b0, 8'h24, 32'h0, 4'hF, irqv);
        wb_xfer(1'b1, 8'h24, 32'h20, 4'hF, irqv);
        check("irq_in_ack_cycle", 64'(irqv), 64'd1);
        check("irq_after_w1c", 64'(irq_o), 64'd0);

        // Rise on pad 3 lands on the same edge as a W1C of bit 3.
        np = gpio_i; np[3] = 1'b0;
        set_pads(np);
        cycle(4);
        np[3] = 1'b1;
        set_pads(np);
        cycle(2);
        wb_xfer(1'b1, 8'h20, 32'h8, 4'h1, irqv);
        m_ist[3] = 1'b1;
        wb_xfer(1'b0, 8'h20, 32'h0, 4'hF, irqv);

        // Load visible state, then reset while an ack is on the bus.
        wb_xfer(1'b1, 8'h18, 32'h8, 4'hF, irqv);
        wb_xfer(1'b1, 8'h04, 32'h15, 4'hF, irqv);
        wb_xfer(1'b1, 8'h08, $urandom(), 4'hF, irqv);
        check("irq_high_pre_rst", 64'(irq_o), 64'd1);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = BASE; wbs_sel_i = 4'hF;
        @(posedge clk);
        #2;
        rst_i = 1'b1;
        #1;
        check("midrst_oeb", 64'(gpio_oeb_no), 64'h3F_FFFF_FFFF);
        check("midrst_gpio_o", 64'(gpio_o), 64'd0);
        check("midrst_irq", 64'(irq_o), 64'd0);
        check("midrst_ack", 64'(wbs_ack_o), 64'd0);
        cycle(2);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        rst_i = 1'b0;
        m_out = '0; m_oeb = '1; m_ien = '0; m_ist = '0;
        acks = 0;
        for (int k = 0; k < 10; k++) begin
            cycle(1);
            acks += int'(wbs_ack_o);
        end
        check("acks_after_rst", 64'(acks), 64'd0);
        wb_xfer(1'b0, 8'h0C, 32'h0, 4'hF, irqv);
        wb_xfer(1'b0, 8'h04, 32'h0, 4'hF, irqv);
        wb_xfer(1'b0, 8'h18, 32'h0, 4'hF, irqv);
        wb_xfer(1'b0, 8'h20, 32'h0, 4'hF, irqv);
        wb_xfer(1'b0, 8'h24, 32'h0, 4'hF, irqv);

        cycle(2);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
